inst_mem_loader: RTL and testbench

Instruction encoder and loader for the five-stage core: accepts decoded instruction fields (opcode, register indices, immediate) over a valid/ready handshake, packs them into 32-bit instruction words using the core's opcode encodings and field layout, and streams each word into the byte-wide instruction memory. It is the write-side counterpart of the fetch/decode path and is used by benches and the boot path to fill instruction memory before the core is released from reset.

---
 rtl/inst_mem_loader.sv | 178 +++++++++++++++++
 tb/tb_inst_mem_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: packs decoded instruction fields into 32-bit words and
// streams them big-endian, one byte per cycle, into the instruction memory.
// Optional feature macro: INST_LOADER_OPCODE_CHECK_EN (illegal opcodes are
// written as NOP and flagged on err_illegal).
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready;
// the producer holds in_* stable until then, and in_ready never depends on
// in_valid.
module inst_mem_loader #(
  parameter int WORD_LEN      = 32,
  parameter int INST_MEM_SIZE = 1024,
  parameter int MEM_CELL_SIZE = 8,
  localparam int AW           = $clog2(INST_MEM_SIZE),
  localparam int CW           = $clog2(INST_MEM_SIZE/4) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_opcode,
  input  logic [4:0]               in_dest,
  input  logic [4:0]               in_src1,
  input  logic [4:0]               in_src2,
  input  logic [15:0]              in_imm,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [MEM_CELL_SIZE-1:0] mem_wdata,
  output logic [CW-1:0]            word_cnt,
  output logic                     full,
  output logic                     err_illegal,
  output logic [2:0]               fsm_state
);

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd3,  OP_AND  = 6'd5,
    OP_OR   = 6'd6,  OP_NOR  = 6'd7,  OP_XOR  = 6'd8,  OP_SLA  = 6'd9,
    OP_SLL  = 6'd10, OP_SRA  = 6'd11, OP_SRL  = 6'd12, OP_ADDI = 6'd32,
    OP_SUBI = 6'd33, OP_LD   = 6'd36, OP_ST   = 6'd37, OP_BEZ  = 6'd40,
    OP_BNE  = 6'd41, OP_JMP  = 6'd42
  } opcode_t;

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

  localparam int WORDS = INST_MEM_SIZE / 4;

  state_t                state_q, state_d;
  logic [WORD_LEN-1:0]   word_q, word_d, enc_word;
  logic [AW-1:0]         base_q;
  logic                  hs;
  logic                  we_d;
  logic [1:0]            idx_d;
  logic [AW-1:0]         addr_d;
  logic [MEM_CELL_SIZE-1:0] wdata_d;

  // Field layout per opcode class; anything unlisted falls into R-type form.
  function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2,
                                         input logic [15:0] imm);
    logic [31:0] w;
    case (op)
      OP_NOP:                  w = 32'd0;
      OP_ADDI, OP_SUBI, OP_LD: w = {op, d, s1, imm};
      OP_ST, OP_BNE:           w = {op, s2, s1, imm};
      OP_BEZ:                  w = {op, 5'd0, s1, imm};
      OP_JMP:                  w = {op, 10'd0, imm};
      default:                 w = {op, d, s1, s2, 11'd0};
    endcase
    return w;
  endfunction

`ifdef INST_LOADER_OPCODE_CHECK_EN
  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLA, OP_SLL,
      OP_SRA, OP_SRL, OP_ADDI, OP_SUBI, OP_LD, OP_ST, OP_BEZ, OP_BNE,
      OP_JMP:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign enc_word = is_legal(in_opcode) ?
                    WORD_LEN'(encode(in_opcode, in_dest, in_src1, in_src2, in_imm)) :
                    '0;
`else
  assign enc_word = WORD_LEN'(encode(in_opcode, in_dest, in_src1, in_src2, in_imm));
`endif

  // clear wins over a same-cycle handshake, so in_ready drops while it is high.
  assign in_ready  = rst_n && (state_q == IDLE) && !full && !clear;
  assign hs        = in_valid && in_ready;
  assign fsm_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the byte that the next state will present.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    we_d    = 1'b0;
    idx_d   = 2'd0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_q)
      IDLE: if (hs) begin
        state_d = B0;
        word_d  = enc_word;
      end
      B0:      state_d = B1;
      B1:      state_d = B2;
      B2:      state_d = B3;
      B3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
    case (state_d)
      B0:      idx_d = 2'd0;
      B1:      idx_d = 2'd1;
      B2:      idx_d = 2'd2;
      B3:      idx_d = 2'd3;
      default: idx_d = 2'd0;
    endcase
    if (state_d != IDLE) begin
      we_d    = 1'b1;
      addr_d  = base_q + AW'(idx_d);
      wdata_d = word_d[WORD_LEN-1 - 32'(idx_d)*MEM_CELL_SIZE -: MEM_CELL_SIZE];
    end
  end

  // Word buffer, registered memory port, base address and fill accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      base_q    <= '0;
      word_cnt  <= '0;
      full      <= 1'b0;
    end else if (clear) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      base_q    <= '0;
      word_cnt  <= '0;
      full      <= 1'b0;
    end else begin
      word_q    <= word_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      if (state_q == B3) begin
        // base wraps to 0 on the last word, the same edge full rises.
        base_q   <= base_q + AW'(4);
        word_cnt <= word_cnt + CW'(1);
        if (word_cnt == CW'(WORDS - 1)) full <= 1'b1;
      end
    end
  end

`ifdef INST_LOADER_OPCODE_CHECK_EN
  // Sticky illegal-opcode flag, set on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_illegal <= 1'b0;
    else if (clear)                       err_illegal <= 1'b0;
    else if (hs && !is_legal(in_opcode))  err_illegal <= 1'b1;
  end
`else
  assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected (address, byte) pairs are
// queued at each accepted word and a negedge monitor checks every memory write.
module tb_inst_mem_loader;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_JMP  = 6'd42;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [4:0]  in_dest = '0, in_src1 = '0, in_src2 = '0;
  logic [15:0] in_imm = '0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [8:0]  word_cnt;
  logic        full;
  logic        err_illegal;
  logic [2:0]  fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] exp_q[$];
  logic [9:0]  exp_addr = '0;

  inst_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_src1(in_src1),
    .in_src2(in_src2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_cnt(word_cnt), .full(full), .err_illegal(err_illegal),
    .fsm_state(fsm_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one word; queue the first nbytes of exp_word as expected writes.
  task automatic send(input logic [5:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [15:0] imm,
                      input logic [31:0] exp_word, input int nbytes);
    int n = 0;
    logic [31:0] w;
    @(negedge clk);
    in_opcode = op; in_dest = d; in_src1 = s1; in_src2 = s2; in_imm = imm;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_ready_timeout: in_ready 0 after %0d cycles, required 1", n);
      in_valid = 1'b0;
    end else begin
      w = exp_word;
      for (int k = 0; k < nbytes; k++)
        exp_q.push_back({exp_addr + 10'(k), w[31-8*k -: 8]});
      exp_addr = exp_addr + 10'd4;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [17:0] e;
    if (mem_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL mem_write: addr 0x%0h data 0x%0h, required addr 0x%0h data 0x%0h",
                   mem_addr, mem_wdata, e[17:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    logic [4:0] fd, fs;
    // Reset state.
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_word_cnt", 32'(word_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // ADD d3 s1 s2 -> 0x04611000.
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 16'h0, 32'h0461_1000, 4);
    check("add_in_ready_busy", 32'(in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("add_word_cnt", 32'(word_cnt), 32'd1);
    check("add_in_ready_back", 32'(in_ready), 32'd1);

    // ADDI, JMP, ST, BEZ back-to-back.
    send(OP_ADDI, 5'd5, 5'd0, 5'd0, 16'h00FF, 32'h80A0_00FF, 4);
    send(OP_JMP,  5'd0, 5'd0, 5'd0, 16'h0010, 32'hA800_0010, 4);
    send(OP_ST,   5'd0, 5'd2, 5'd7, 16'h1234, 32'h94E2_1234, 4);
    send(OP_BEZ,  5'd9, 5'd4, 5'd0, 16'hFFFE, 32'hA004_FFFE, 4);
    repeat (5) @(posedge clk);
    #1;
    check("seq_word_cnt", 32'(word_cnt), 32'd5);

    // Illegal opcode.
`ifdef INST_LOADER_OPCODE_CHECK_EN
    send(6'h3F, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0000_0000, 4);
    check("illegal_err", 32'(err_illegal), 32'd1);
`else
    send(6'h3F, 5'd0, 5'd0, 5'd0, 16'h0, 32'hFC00_0000, 4);
    check("illegal_err", 32'(err_illegal), 32'd0);
`endif
    repeat (5) @(posedge clk);

    // clear resets counters and the sticky flag.
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    exp_addr = '0;
    check("clear_word_cnt", 32'(word_cnt), 32'd0);
    check("clear_err", 32'(err_illegal), 32'd0);

    // clear during B1: only bytes 0 and 1 land.
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 16'h0, 32'h0461_1000, 2);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    check("midclear_mem_we", 32'(mem_we), 32'd0);
    check("midclear_word_cnt", 32'(word_cnt), 32'd0);
    exp_addr = '0;
    repeat (6) @(posedge clk);

    // clear with a same-cycle offer: offer ignored.
    @(negedge clk);
    in_opcode = OP_ADD; in_valid = 1'b1; clear = 1'b1;
    #1 check("clear_hs_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0; clear = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("clear_hs_word_cnt", 32'(word_cnt), 32'd0);

    // Fill all 256 words.
    for (int i = 0; i < 256; i++) begin
      fd = 5'(i); fs = 5'(i >> 3);
      send(OP_ADD, fd, fs, ~fd, 16'h0, {OP_ADD, fd, fs, ~fd, 11'd0}, 4);
    end
    repeat (5) @(posedge clk);
    #1;
    check("fill_full", 32'(full), 32'd1);
    check("fill_word_cnt", 32'(word_cnt), 32'd256);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); in_opcode = OP_ADD; in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("full_ignores_valid", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    exp_addr = '0;
    check("full_clear_cnt", 32'(word_cnt), 32'd0);
    check("full_clear_addr", 32'(mem_addr), 32'd0);
    check("full_clear_full", 32'(full), 32'd0);
    @(negedge clk);
    check("full_clear_ready", 32'(in_ready), 32'd1);

    // Async reset in B2.
    send(OP_JMP, 5'd0, 5'd0, 5'd0, 16'h0010, 32'hA800_0010, 2);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_b2_mem_we", 32'(mem_we), 32'd0);
    check("rst_b2_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_b2_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_b2_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_addr = '0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_b2_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_b2_ready_after", 32'(in_ready), 32'd1);

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
